// File: rtl/m_receiver.sv
// rtl/m_receiver.sv - 8N1 serial frame receiver with FWFT byte FIFO and idle-time frame delimiting.
// Optional even-parity bit per byte when RX_PARITY_EN is defined.
module m_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 16,
  parameter int IDLE_BITS    = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  input  logic        i_data_re,
  input  logic        i_frame_ack,
  input  logic        i_status_clr,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic [15:0] o_data_size,
  output logic [7:0]  o_frames_count,
  output logic        o_frame_done,
  output logic [7:0]  o_status
);

  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int IDLE_LIM = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W   = $clog2(IDLE_LIM);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state_q, state_d;
  logic               rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]   bit_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               sample;
  logic               stop_smp, commit, wr_en, rd_en, full, empty;
  logic               ovf_evt, frm_evt, par_evt, par_bad;
  logic [7:0]         mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W:0]    count;
  logic               frame_open, close;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [7:0]         frames;
  logic               sticky_ovf, sticky_frm, sticky_par;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    sample  = 1'b0;
    state_d = state_q;
    if (state_q == S_START) sample = (bit_cnt == CNT_W'(HALF - 1));
    else                    sample = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    case (state_q)
      S_IDLE:   if (rx_prev && !rx_sync) state_d = S_START;
      S_START:  if (sample) state_d = rx_sync ? S_IDLE : S_DATA;
      S_DATA: begin
        if (sample && bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (sample) state_d = S_STOP;
      S_STOP:   if (sample) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Bit timer restarts on every sample so each bit is timed from the previous sample point.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state_q == S_IDLE || sample) bit_cnt <= '0;
      else                             bit_cnt <= bit_cnt + 1'b1;
      if (state_q == S_START) bit_idx <= '0;
      else if (state_q == S_DATA && sample) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {rx_sync, shreg[7:1]};
      end
    end
  end

`ifdef RX_PARITY_EN
  assign par_evt = (state_q == S_PARITY) && sample && (rx_sync != ^shreg);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   par_bad <= 1'b0;
    else if (state_q == S_START) par_bad <= 1'b0;
    else if (par_evt)            par_bad <= 1'b1;
  end
`else
  assign par_evt = 1'b0;
  assign par_bad = 1'b0;
`endif

  assign empty    = (count == '0);
  assign full     = (count == (ADDR_W + 1)'(DEPTH));
  assign stop_smp = (state_q == S_STOP) && sample;
  assign commit   = stop_smp && rx_sync && !par_bad;
  assign wr_en    = commit && !full;
  assign rd_en    = i_data_re && !empty;
  assign ovf_evt  = commit && full;
  assign frm_evt  = stop_smp && !rx_sync;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (!wr_en && rd_en) count <= count - 1'b1;
    end
  end

  // A frame stays open until the line has been high for the full idle window while idle.
  assign close = (state_q == S_IDLE) && frame_open && rx_sync &&
                 (idle_cnt == IDLE_W'(IDLE_LIM - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_open <= 1'b0;
      idle_cnt   <= '0;
    end else if (wr_en) begin
      frame_open <= 1'b1;
      idle_cnt   <= '0;
    end else if (close) begin
      frame_open <= 1'b0;
      idle_cnt   <= '0;
    end else if (state_q != S_IDLE || !rx_sync) begin
      idle_cnt <= '0;
    end else if (frame_open) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frames <= '0;
    end else if (close) begin
      if (!i_frame_ack && frames != 8'hFF) frames <= frames + 1'b1;
    end else if (i_frame_ack && frames != '0) begin
      frames <= frames - 1'b1;
    end
  end

  // Error events take priority over a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_ovf <= 1'b0;
      sticky_frm <= 1'b0;
      sticky_par <= 1'b0;
    end else begin
      sticky_ovf <= (sticky_ovf && !i_status_clr) || ovf_evt;
      sticky_frm <= (sticky_frm && !i_status_clr) || frm_evt;
      sticky_par <= (sticky_par && !i_status_clr) || par_evt;
    end
  end

  assign o_data         = empty ? 8'h00 : mem[rd_ptr];
  assign o_data_valid   = !empty;
  assign o_data_size    = 16'(count);
  assign o_frames_count = frames;
  assign o_frame_done   = close;
  assign o_status       = {2'b00, (state_q != S_IDLE) || frame_open,
                           sticky_par, sticky_frm, sticky_ovf, full, empty};

endmodule
